// File: rtl/z80_block_seq.sv
// rtl/z80_block_seq.sv - ED block transfer/compare sequencer (LDI/LDD/LDIR/LDDR/CPI/CPD/CPIR/CPDR)
// One clock per T-state; outputs are registered, results land in the done cycle.
module z80_block_seq #(
   parameter int INTERNAL_T = 5,
   parameter int REPEAT_T   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        op_cp,
   input  logic        op_dec,
   input  logic        op_rep,
   input  logic [7:0]  reg_a_in,
   input  logic [7:0]  reg_f_in,
   input  logic [15:0] reg_bc_in,
   input  logic [15:0] reg_de_in,
   input  logic [15:0] reg_hl_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic [2:0]  mcycle_type,
   output logic        busy,
   output logic        done,
   output logic        rewind,
   output logic [15:0] reg_bc_out,
   output logic [15:0] reg_de_out,
   output logic [15:0] reg_hl_out,
   output logic [7:0]  reg_f_out
);
   localparam logic [2:0] CYCLE_NONE     = 3'd0;
   localparam logic [2:0] CYCLE_RDWR_MEM = 3'd1;
   localparam logic [2:0] CYCLE_INTERNAL = 3'd2;

   localparam logic [7:0] INT_LAST     = 8'(INTERNAL_T - 1);
   localparam logic [7:0] REP_LAST     = 8'(REPEAT_T - 1);
   // The write M-cycle carries two extra T-states after the bus completes.
   localparam logic [7:0] WR_TAIL_LAST = 8'd1;

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_INT, S_REP, S_DONE} state_t;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic        op_cp_q, op_dec_q, op_rep_q;
   logic [7:0]  a_q, f_q, d_q;
   logic [15:0] bc_q, de_q, hl_q;

   logic        mem_req_q, mem_we_q, busy_q, done_q, rewind_q;
   logic [15:0] mem_addr_q;
   logic [7:0]  mem_wdata_q;
   logic [2:0]  mcycle_q;
   logic [15:0] bc_out_q, de_out_q, hl_out_q;
   logic [7:0]  f_out_q;

   logic [7:0]  r_d, f_d;
   logic [15:0] bc_d, de_d, hl_d;
   logic        z_d, pv_d, rep_d, work_end_d, rep_end_d;

   always_comb begin
      r_d  = a_q - d_q;
      z_d  = (r_d == 8'h00);
      pv_d = (bc_q != 16'h0001);
      bc_d = bc_q - 16'd1;
      hl_d = op_dec_q ? hl_q - 16'd1 : hl_q + 16'd1;
      de_d = de_q;
      if (!op_cp_q) begin
         de_d = op_dec_q ? de_q - 16'd1 : de_q + 16'd1;
      end
      if (op_cp_q) begin
         f_d = {r_d[7], z_d, f_q[5], (a_q[3:0] < d_q[3:0]), f_q[3], pv_d, 1'b1, f_q[0]};
      end else begin
         f_d = {f_q[7:5], 1'b0, f_q[3], pv_d, 1'b0, f_q[0]};
      end
      rep_d      = op_rep_q && (bc_d != 16'h0000) && (!op_cp_q || !z_d);
      // Last T-state of WRITE or INT: the repeat decision is taken here.
      work_end_d = ((state_q == S_WRITE) && !mem_req_q && (cnt_q == WR_TAIL_LAST)) ||
                   ((state_q == S_INT) && (cnt_q == INT_LAST));
      rep_end_d  = (state_q == S_REP) && (cnt_q == REP_LAST);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         op_cp_q     <= 1'b0;
         op_dec_q    <= 1'b0;
         op_rep_q    <= 1'b0;
         a_q         <= 8'h00;
         f_q         <= 8'h00;
         d_q         <= 8'h00;
         bc_q        <= 16'h0000;
         de_q        <= 16'h0000;
         hl_q        <= 16'h0000;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 16'h0000;
         mem_wdata_q <= 8'h00;
         mcycle_q    <= CYCLE_NONE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rewind_q    <= 1'b0;
         bc_out_q    <= 16'h0000;
         de_out_q    <= 16'h0000;
         hl_out_q    <= 16'h0000;
         f_out_q     <= 8'h00;
      end else begin
         done_q <= 1'b0;
         if (rep_end_d || (work_end_d && !rep_d)) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            mcycle_q <= CYCLE_NONE;
            rewind_q <= rep_d;
            bc_out_q <= bc_d;
            de_out_q <= de_d;
            hl_out_q <= hl_d;
            f_out_q  <= f_d;
         end else if (work_end_d) begin
            state_q  <= S_REP;
            cnt_q    <= 8'd0;
            mcycle_q <= CYCLE_INTERNAL;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     op_cp_q    <= op_cp;
                     op_dec_q   <= op_dec;
                     op_rep_q   <= op_rep;
                     a_q        <= reg_a_in;
                     f_q        <= reg_f_in;
                     bc_q       <= reg_bc_in;
                     de_q       <= reg_de_in;
                     hl_q       <= reg_hl_in;
                     state_q    <= S_READ;
                     busy_q     <= 1'b1;
                     mem_req_q  <= 1'b1;
                     mem_we_q   <= 1'b0;
                     mem_addr_q <= reg_hl_in;
                     mcycle_q   <= CYCLE_RDWR_MEM;
                  end
               end
               S_READ: begin
                  if (mem_ack) begin
                     d_q         <= mem_rdata;
                     mem_wdata_q <= mem_rdata;
                     cnt_q       <= 8'd0;
                     if (op_cp_q) begin
                        mem_req_q <= 1'b0;
                        mcycle_q  <= CYCLE_INTERNAL;
                        state_q   <= S_INT;
                     end else begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= de_q;
                        state_q    <= S_WRITE;
                     end
                  end
               end
               S_WRITE: begin
                  if (mem_req_q) begin
                     if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        cnt_q     <= 8'd0;
                     end
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
               S_INT, S_REP: cnt_q <= cnt_q + 8'd1;
               S_DONE:       state_q <= S_IDLE;
               default:      state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mcycle_type = mcycle_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign rewind      = rewind_q;
   assign reg_bc_out  = bc_out_q;
   assign reg_de_out  = de_out_q;
   assign reg_hl_out  = hl_out_q;
   assign reg_f_out   = f_out_q;
endmodule

// File: tb/tb_z80_block_seq.sv
// tb/tb_z80_block_seq.sv - randomized bench for z80_block_seq against a per-cycle timeline model
module tb_z80_block_seq;
   localparam int IT = 5;
   localparam int RT = 5;
   localparam logic [2:0] CYC_NONE = 3'd0;
   localparam logic [2:0] CYC_MEM  = 3'd1;
   localparam logic [2:0] CYC_INT  = 3'd2;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, op_cp, op_dec, op_rep;
   logic [7:0]  reg_a_in, reg_f_in;
   logic [15:0] reg_bc_in, reg_de_in, reg_hl_in;
   logic        mem_req, mem_we, mem_ack;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic [2:0]  mcycle_type;
   logic        busy, done, rewind;
   logic [15:0] reg_bc_out, reg_de_out, reg_hl_out;
   logic [7:0]  reg_f_out;

   z80_block_seq #(.INTERNAL_T(IT), .REPEAT_T(RT)) dut (
      .clk(clk), .reset(reset), .start(start), .op_cp(op_cp), .op_dec(op_dec), .op_rep(op_rep),
      .reg_a_in(reg_a_in), .reg_f_in(reg_f_in), .reg_bc_in(reg_bc_in), .reg_de_in(reg_de_in),
      .reg_hl_in(reg_hl_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mcycle_type(mcycle_type),
      .busy(busy), .done(done), .rewind(rewind), .reg_bc_out(reg_bc_out), .reg_de_out(reg_de_out),
      .reg_hl_out(reg_hl_out), .reg_f_out(reg_f_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bc, de, hl;
      logic [7:0]  f;
      logic        rep;
   } res_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_lat = 0;

   logic [7:0]  mem [0:65535];
   int          rd_wait = 0, wr_wait = 0;
   logic        spur_en = 1'b0;

   logic        active = 1'b0;
   int          s_cyc = 0;
   logic        m_cp, m_dec, m_rep;
   logic [7:0]  m_a, m_f, m_d;
   logic [15:0] m_bc, m_de, m_hl;
   int          m_rw, m_ww;
   logic [15:0] h_bc = 0, h_de = 0, h_hl = 0;
   logic [7:0]  h_f = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic res_t model(input logic cp, dec, rep, input logic [7:0] a, f, d,
                                  input logic [15:0] bc, de, hl);
      res_t o;
      int   r;
      bit   s, z, h, pv;
      o.bc = bc - 16'd1;
      o.hl = dec ? hl - 16'd1 : hl + 16'd1;
      o.de = cp ? de : (dec ? de - 16'd1 : de + 16'd1);
      r  = (int'(a) - int'(d)) & 255;
      s  = (r >= 128);
      z  = (r == 0);
      h  = (int'(a % 16) - int'(d % 16)) < 0;
      pv = (bc != 16'd1);
      if (cp) o.f = {s, z, f[5], h, f[3], pv, 1'b1, f[0]};
      else    o.f = {f[7], f[6], f[5], 1'b0, f[3], pv, 1'b0, f[0]};
      o.rep = rep && (o.bc != 16'd0) && (!cp || !z);
      return o;
   endfunction

   // Zero-wait bus unit acks on the 3rd request cycle, plus programmed wait states.
   int rcnt = 0;
   always @(negedge clk) begin
      if (reset) begin
         mem_ack = 1'b0;
         rcnt = 0;
      end else begin
         if (mem_ack) rcnt = 0;
         mem_ack = 1'b0;
         mem_rdata = 8'($urandom);
         if (mem_req) begin
            rcnt++;
            if (rcnt == 3 + (mem_we ? wr_wait : rd_wait)) begin
               mem_ack = 1'b1;
               if (mem_we) mem[mem_addr] = mem_wdata;
               else        mem_rdata = mem[mem_addr];
            end
         end else begin
            rcnt = 0;
            if (spur_en && ($urandom_range(0, 3) == 0)) mem_ack = 1'b1;
         end
      end
   end

   always begin : cmp
      int j, base, dn;
      res_t r;
      logic e_req, e_we, e_wr, e_busy, e_done;
      logic [2:0] e_mc;
      logic [15:0] e_addr;
      @(posedge clk);
      cyc++;
      #1;
      if (!reset) begin
         e_req = 0; e_we = 0; e_wr = 0; e_busy = 0; e_done = 0; e_mc = CYC_NONE; e_addr = 0;
         if (active && (cyc >= s_cyc)) begin
            j = cyc - s_cyc;
            r = model(m_cp, m_dec, m_rep, m_a, m_f, m_d, m_bc, m_de, m_hl);
            base = m_cp ? 3 + m_rw + IT : 8 + m_rw + m_ww;
            dn = base + (r.rep ? RT : 0);
            if (j <= 2 + m_rw) begin
               e_req = 1; e_mc = CYC_MEM; e_addr = m_hl; e_busy = 1;
            end else if (!m_cp && j <= 5 + m_rw + m_ww) begin
               e_req = 1; e_we = 1; e_wr = 1; e_mc = CYC_MEM; e_addr = m_de; e_busy = 1;
            end else if (!m_cp && j < base) begin
               e_mc = CYC_MEM; e_busy = 1;
            end else if (j < dn) begin
               e_mc = CYC_INT; e_busy = 1;
            end else begin
               e_done = 1;
               h_bc = r.bc; h_de = r.de; h_hl = r.hl; h_f = r.f;
               last_lat = j;
               active = 0;
               chk("rewind", 32'(rewind), 32'(r.rep));
            end
         end
         chk("busy", 32'(busy), 32'(e_busy));
         chk("done", 32'(done), 32'(e_done));
         chk("mcycle_type", 32'(mcycle_type), 32'(e_mc));
         chk("mem_req", 32'(mem_req), 32'(e_req));
         if (e_req) begin
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
         end
         if (e_wr) chk("mem_wdata", 32'(mem_wdata), 32'(m_d));
         chk("bc_out", 32'(reg_bc_out), 32'(h_bc));
         chk("de_out", 32'(reg_de_out), 32'(h_de));
         chk("hl_out", 32'(reg_hl_out), 32'(h_hl));
         chk("f_out", 32'(reg_f_out), 32'(h_f));
      end
   end

   task automatic scramble_inputs();
      op_cp = 1'($urandom); op_dec = 1'($urandom); op_rep = 1'($urandom);
      reg_a_in = 8'($urandom); reg_f_in = 8'($urandom);
      reg_bc_in = 16'($urandom); reg_de_in = 16'($urandom); reg_hl_in = 16'($urandom);
   endtask

   task automatic launch(input logic cp, dec, rep, input logic [7:0] a, f, d,
                         input logic [15:0] bc, de, hl, input int rw, ww);
      @(negedge clk);
      mem[hl] = d;
      rd_wait = rw; wr_wait = ww;
      m_cp = cp; m_dec = dec; m_rep = rep; m_a = a; m_f = f; m_d = d;
      m_bc = bc; m_de = de; m_hl = hl; m_rw = rw; m_ww = ww;
      s_cyc = cyc + 1;
      active = 1;
      start = 1; op_cp = cp; op_dec = dec; op_rep = rep;
      reg_a_in = a; reg_f_in = f; reg_bc_in = bc; reg_de_in = de; reg_hl_in = hl;
   endtask

   task automatic run_op(input logic cp, dec, rep, input logic [7:0] a, f, d,
                         input logic [15:0] bc, de, hl, input int rw, ww, input logic junk);
      launch(cp, dec, rep, a, f, d, bc, de, hl, rw, ww);
      for (int n = 0; n < 400 && active; n++) begin
         @(negedge clk);
         scramble_inputs();
         start = junk && (n == 2 || done);
      end
      if (active) begin
         checks++; errors++;
         $display("FAIL timeout: done not seen within 400 cycles of start");
         active = 0;
      end
      @(negedge clk);
      start = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1; start = 0; op_cp = 0; op_dec = 0; op_rep = 0;
      reg_a_in = 0; reg_f_in = 0; reg_bc_in = 0; reg_de_in = 0; reg_hl_in = 0;
      repeat (3) @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_mcycle", 32'(mcycle_type), 32'(CYC_NONE));
      chk("rst_f_out", 32'(reg_f_out), 32'(0));
      reset = 0;
      repeat (2) @(negedge clk);

      run_op(1, 1, 0, 8'h40, 8'h29, 8'h40, 16'h0002, 16'h5555, 16'h1000, 0, 0, 0);
      chk("cpd_f", 32'(reg_f_out), 32'h6F);
      chk("cpd_hl", 32'(reg_hl_out), 32'h0FFF);
      chk("cpd_bc", 32'(reg_bc_out), 32'h0001);
      chk("cpd_rewind", 32'(rewind), 32'(0));
      chk("cpd_latency", 32'(last_lat), 32'(8));

      run_op(1, 0, 1, 8'h10, 8'h00, 8'h11, 16'h0003, 16'h1234, 16'h2000, 0, 0, 1);
      chk("cpir_f", 32'(reg_f_out), 32'h96);
      chk("cpir_bc", 32'(reg_bc_out), 32'h0002);
      chk("cpir_rewind", 32'(rewind), 32'(1));
      chk("cpir_latency", 32'(last_lat), 32'(13));

      run_op(1, 0, 1, 8'h10, 8'h00, 8'h10, 16'h0003, 16'h1234, 16'h2100, 0, 0, 0);
      chk("cpir_match_f", 32'(reg_f_out), 32'h46);
      chk("cpir_match_rewind", 32'(rewind), 32'(0));

      run_op(0, 1, 1, 8'h00, 8'hFF, 8'hAB, 16'h0001, 16'h4000, 16'h3000, 0, 0, 0);
      chk("lddr_mem", 32'(mem[16'h4000]), 32'hAB);
      chk("lddr_hl", 32'(reg_hl_out), 32'h2FFF);
      chk("lddr_de", 32'(reg_de_out), 32'h3FFF);
      chk("lddr_bc", 32'(reg_bc_out), 32'h0000);
      chk("lddr_f", 32'(reg_f_out), 32'hE9);
      chk("lddr_rewind", 32'(rewind), 32'(0));

      run_op(0, 0, 1, 8'h00, 8'h00, 8'h5A, 16'h0000, 16'h5000, 16'h6000, 0, 0, 0);
      chk("ldir_bc0_bc", 32'(reg_bc_out), 32'hFFFF);
      chk("ldir_bc0_f", 32'(reg_f_out), 32'h04);
      chk("ldir_bc0_rewind", 32'(rewind), 32'(1));
      chk("ldir_bc0_latency", 32'(last_lat), 32'(13));

      run_op(1, 0, 0, 8'h22, 8'h00, 8'h22, 16'h0005, 16'h0000, 16'h7000, 2, 0, 0);
      chk("wait2_latency", 32'(last_lat), 32'(10));

      // Abort in the middle of the internal cycle.
      launch(1, 0, 0, 8'h01, 8'h00, 8'h02, 16'h0009, 16'h0000, 16'h7100, 0, 0);
      @(negedge clk);
      start = 0;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #3 reset = 1;
      active = 0;
      h_bc = 0; h_de = 0; h_hl = 0; h_f = 0;
      #1;
      chk("abort_mem_req", 32'(mem_req), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_done", 32'(done), 32'(0));
      chk("abort_rewind", 32'(rewind), 32'(0));
      chk("abort_mcycle", 32'(mcycle_type), 32'(CYC_NONE));
      chk("abort_addr", 32'(mem_addr), 32'(0));
      chk("abort_bc_out", 32'(reg_bc_out), 32'(0));
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      repeat (3) @(negedge clk);
      run_op(1, 0, 0, 8'h30, 8'h00, 8'h31, 16'h0004, 16'h0000, 16'h7200, 0, 0, 1);
      chk("post_abort_bc", 32'(reg_bc_out), 32'h0003);
      chk("post_abort_latency", 32'(last_lat), 32'(8));

      for (int i = 0; i < 40; i++) begin
         logic        cp;
         logic [7:0]  a, d;
         logic [15:0] bc;
         int          sel;
         cp  = 1'($urandom);
         a   = 8'($urandom);
         d   = (cp && ($urandom_range(0, 2) == 0)) ? a : 8'($urandom);
         sel = $urandom_range(0, 3);
         bc  = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'h0001 : (sel == 2) ? 16'h0002 : 16'($urandom);
         spur_en = 1'($urandom);
         run_op(cp, 1'($urandom), 1'($urandom), a, 8'($urandom), d, bc, 16'($urandom),
                16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      end
      spur_en = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
